// File: rtl/comparator_seq_param_if.sv
// Operand/result handshake bundle for the sequential comparator.
// master = producer/consumer side, slave = comparator side.
interface comparator_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             gr;
    logic             lt;
    logic             eq;
    logic             busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, gr, lt, eq, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, gr, lt, eq, busy
    );
endinterface

// File: rtl/comparator_seq_param.sv
// Chunk-serial magnitude comparator, MSB chunk first, early exit on
// the first differing chunk. Signed mode biases the MSB and compares unsigned.
module comparator_seq_param #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input logic                    clk,
    input logic                    rst,
    comparator_seq_param_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0]    LAST = KW'(NCH - 1);
    localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
        $error("comparator_seq_param: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             gr_q, gr_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_top;
    logic [CHUNK-1:0] b_top;

    assign a_top = a_q[WIDTH-1 -: CHUNK];
    assign b_top = b_q[WIDTH-1 -: CHUNK];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        gr_d        = gr_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a ^ (bus.signed_mode ? MSB : '0);
                    b_d     = bus.b ^ (bus.signed_mode ? MSB : '0);
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (a_top != b_top) begin
                    gr_d        = a_top > b_top;
                    lt_d        = a_top < b_top;
                    eq_d        = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (k_q == LAST) begin
                    gr_d        = 1'b0;
                    lt_d        = 1'b0;
                    eq_d        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    a_d = a_q << CHUNK;
                    b_d = b_q << CHUNK;
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    gr_d        = 1'b0;
                    lt_d        = 1'b0;
                    eq_d        = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            gr_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            gr_q        <= gr_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is gated by rst so nothing is taken while reset is held
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = out_valid_q;
    assign bus.gr        = gr_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
endmodule

// File: tb/tb_comparator_seq_param.sv
// Directed and randomized checks of the chunk-serial comparator,
// 32/4 main instance plus a 16/16 single-chunk instance.
module tb_comparator_seq_param;
    localparam logic [2:0] GR = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    comparator_seq_param_if #(.WIDTH(32)) bus ();
    comparator_seq_param_if #(.WIDTH(16)) bus16 ();

    comparator_seq_param #(.WIDTH(32), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    comparator_seq_param #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_res(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sm);
        if (sm) begin
            if ($signed(a) > $signed(b)) return GR;
            if ($signed(a) < $signed(b)) return LT;
        end else begin
            if (a > b) return GR;
            if (a < b) return LT;
        end
        return EQ;
    endfunction

    // edges from accept to out_valid: 1-based index of first differing nibble
    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 8; i++)
            if (a[31-4*i -: 4] != b[31-4*i -: 4]) return i + 1;
        return 8;
    endfunction

    function automatic logic [2:0] res16(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic sm);
        if (sm) begin
            if ($signed(a) > $signed(b)) return GR;
            if ($signed(a) < $signed(b)) return LT;
        end else begin
            if (a > b) return GR;
            if (a < b) return LT;
        end
        return EQ;
    endfunction

    // called at posedge+1 with the DUT idle; returns at posedge+1 with out_valid seen
    task automatic do_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic sm,
                         input int exp_lat, input logic [2:0] exp_res);
        int lat;
        check({tag, ":in_ready"}, bus.in_ready, 1);
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = sm;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.a           = ~a;
        bus.b           = a;
        bus.signed_mode = ~sm;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":result"}, {bus.gr, bus.lt, bus.eq}, exp_res);
    endtask

    task automatic retire(input string tag);
        @(posedge clk);
        #1;
        check({tag, ":ov_clear"}, {bus.out_valid, bus.gr, bus.lt, bus.eq}, 0);
        check({tag, ":idle"}, {bus.in_ready, bus.busy}, 2'b10);
    endtask

    task automatic op(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic sm,
                      input int exp_lat, input logic [2:0] exp_res);
        do_op(tag, a, b, sm, exp_lat, exp_res);
        retire(tag);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [15:0] sa, sb;
        logic        rs;
        int          n;

        bus.in_valid      = 1'b0;
        bus.a             = '0;
        bus.b             = '0;
        bus.signed_mode   = 1'b0;
        bus.out_ready     = 1'b1;
        bus16.in_valid    = 1'b0;
        bus16.a           = '0;
        bus16.b           = '0;
        bus16.signed_mode = 1'b0;
        bus16.out_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst:outs", {bus.out_valid, bus.gr, bus.lt, bus.eq, bus.busy}, 0);
        check("rst:in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst:release_ready", bus.in_ready, 1);

        op("msb_u", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, GR);
        op("msb_s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, LT);
        op("last_u", 32'hCCCC_CCCC, 32'hCCCC_CCCB, 1'b0, 8, GR);
        op("last_s", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 8, LT);
        op("eq6d_u", 32'h6D6D_6D6D, 32'h6D6D_6D6D, 1'b0, 8, EQ);
        op("eq6d_s", 32'h6D6D_6D6D, 32'h6D6D_6D6D, 1'b1, 8, EQ);
        op("eq0_u", 32'h0, 32'h0, 1'b0, 8, EQ);
        op("eq0_s", 32'h0, 32'h0, 1'b1, 8, EQ);
        op("neg1_s", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, LT);
        op("mid_u", 32'h1234_5678, 32'h1239_5678, 1'b0, 4, LT);

        bus.out_ready = 1'b0;
        do_op("bp", 32'h1, 32'h0, 1'b0, 8, GR);
        for (int i = 0; i < 5; i++) begin
            bus.a        = 32'h0;
            bus.b        = 32'hFFFF_FFFF;
            bus.in_valid = (i % 2) == 0;
            @(posedge clk);
            #1;
            check("bp:hold", {bus.out_valid, bus.gr, bus.lt, bus.eq}, 4'b1100);
            check("bp:in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        retire("bp");
        @(posedge clk);
        #1;
        check("bp:no_accept", {bus.busy, bus.out_valid}, 0);

        bus.a           = 32'h5555_5555;
        bus.b           = 32'h5555_5555;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort:busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort:outs", {bus.out_valid, bus.gr, bus.lt, bus.eq, bus.busy}, 0);
        check("abort:in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("abort:ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        op("after_abort", 32'h1, 32'h0, 1'b0, 8, GR);

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                2: rb = ra ^ 32'h8000_0000;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            do_op("rnd", ra, rb, rs, ref_lat(ra, rb), ref_res(ra, rb, rs));
            n = $urandom_range(0, 2);
            if (n > 0) begin
                bus.out_ready = 1'b0;
                repeat (n) begin
                    @(posedge clk);
                    #1;
                    check("rnd:stall", {bus.out_valid, bus.gr, bus.lt, bus.eq},
                          {1'b1, ref_res(ra, rb, rs)});
                end
                bus.out_ready = 1'b1;
            end
            retire("rnd");
        end

        for (int i = 0; i < 40; i++) begin
            sa = 16'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? sa : 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            bus16.a           = sa;
            bus16.b           = sb;
            bus16.signed_mode = rs;
            bus16.in_valid    = 1'b1;
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("w16:result", {bus16.out_valid, bus16.gr, bus16.lt, bus16.eq},
                  {1'b1, res16(sa, sb, rs)});
            @(posedge clk);
            #1;
            check("w16:clear", {bus16.out_valid, bus16.in_ready}, 2'b01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
